// File: rtl/pc_fetch.sv
// Instruction fetch stage: one outstanding read at a time, holds the fetched
// word until decode takes it, and redirects on branch/jump from execute.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        b_flag_i,
    input  logic [31:0] b_target_addr_i,
    input  logic        stall_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] redirect_addr;
    logic        kill;
    logic [31:0] target;

    assign target      = {b_target_addr_i[31:2], 2'b00};
    assign mem_addr_o  = fetch_pc;
    assign stall_req_o = (state == REQ) && !mem_ack_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            redirect_addr <= '0;
            kill          <= 1'b0;
            mem_req_o     <= 1'b0;
            pc_o          <= '0;
            inst_o        <= '0;
            inst_valid_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (b_flag_i) begin
                        fetch_pc <= target;
                    end
                    state     <= REQ;
                    mem_req_o <= 1'b1;
                end
                REQ: begin
                    if (b_flag_i) begin
                        if (mem_ack_i) begin
                            fetch_pc <= target;
                            kill     <= 1'b0;
                        end else begin
                            // The bus read cannot be withdrawn; remember where to go once it lands.
                            kill          <= 1'b1;
                            redirect_addr <= target;
                        end
                    end else if (mem_ack_i) begin
                        if (kill) begin
                            fetch_pc <= redirect_addr;
                            kill     <= 1'b0;
                        end else begin
                            inst_o       <= mem_data_i;
                            pc_o         <= fetch_pc;
                            inst_valid_o <= 1'b1;
                            fetch_pc     <= fetch_pc + 32'd4;
                            state        <= HOLD;
                            mem_req_o    <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (b_flag_i) begin
                        fetch_pc     <= target;
                        inst_valid_o <= 1'b0;
                        state        <= REQ;
                        mem_req_o    <= 1'b1;
                    end else if (!stall_i) begin
                        inst_valid_o <= 1'b0;
                        state        <= REQ;
                        mem_req_o    <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: directed scenarios plus random traffic against a
// transaction-level model of the fetch stage.
module tb_pc_fetch;

    logic        clk;
    logic        rst;
    logic        b_flag;
    logic [31:0] b_target;
    logic        stall;
    logic        ack;
    logic [31:0] data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall_req;

    logic        rst_w;
    logic        b_flag_w;
    logic [31:0] b_target_w;
    logic        stall_w;
    logic        ack_w;
    logic [31:0] data_w;
    logic        mem_req_w;
    logic [31:0] mem_addr_w;
    logic [31:0] pc_w;
    logic [31:0] inst_w;
    logic        inst_valid_w;
    logic        stall_req_w;

    logic [97:0] obs;
    logic [97:0] obs_w;

    int passed = 0;
    int total  = 0;

    pc_fetch dut (
        .clk(clk), .rst(rst), .b_flag_i(b_flag), .b_target_addr_i(b_target),
        .stall_i(stall), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(ack), .mem_data_i(data), .pc_o(pc), .inst_o(inst),
        .inst_valid_o(inst_valid), .stall_req_o(stall_req)
    );

    pc_fetch #(.RESET_PC(32'hFFFFFFFC)) dut_w (
        .clk(clk), .rst(rst_w), .b_flag_i(b_flag_w), .b_target_addr_i(b_target_w),
        .stall_i(stall_w), .mem_req_o(mem_req_w), .mem_addr_o(mem_addr_w),
        .mem_ack_i(ack_w), .mem_data_i(data_w), .pc_o(pc_w), .inst_o(inst_w),
        .inst_valid_o(inst_valid_w), .stall_req_o(stall_req_w)
    );

    assign obs   = {mem_req, mem_addr, inst_valid, pc, inst};
    assign obs_w = {mem_req_w, mem_addr_w, inst_valid_w, pc_w, inst_w};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: the stage either has an instruction parked for decode,
    // or (once the post-reset bubble is over) has a read outstanding at m_next.
    // redir_q holds the newest redirect deferred behind an in-flight read.
    bit          m_started;
    bit          m_have;
    logic [31:0] m_next;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] redir_q[$];

    task automatic model_reset();
        m_started = 0;
        m_have    = 0;
        m_next    = 32'h0;
        m_pc      = 32'h0;
        m_inst    = 32'h0;
        redir_q.delete();
    endtask

    task automatic model_step();
        logic [31:0] tgt;
        tgt = b_target & 32'hFFFFFFFC;
        if (!m_started) begin
            m_started = 1;
            if (b_flag) m_next = tgt;
        end else if (m_have) begin
            if (b_flag) begin
                m_have = 0;
                m_next = tgt;
            end else if (!stall) begin
                m_have = 0;
            end
        end else begin
            if (b_flag) begin
                redir_q.delete();
                if (ack) m_next = tgt;
                else     redir_q.push_back(tgt);
            end else if (ack) begin
                if (redir_q.size() != 0) begin
                    m_next = redir_q.pop_front();
                end else begin
                    m_have = 1;
                    m_pc   = m_next;
                    m_inst = data;
                    m_next = m_next + 32'd4;
                end
            end
        end
    endtask

    task automatic clear_inputs();
        b_flag   = 1'b0;
        b_target = 32'h0;
        stall    = 1'b0;
        ack      = 1'b0;
        data     = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++;
        if (obs !== 98'h0) $display("FAIL reset_outputs got=%h exp=%h", obs, 98'h0);
        else passed++;
        total++;
        if (stall_req !== 1'b0) $display("FAIL reset_stall_req got=%b exp=0", stall_req);
        else passed++;
    endtask

    task automatic test_sequence();
        logic [31:0] a;
        do_reset();
        tick();
        for (int k = 0; k < 3; k++) begin
            a = 32'(4 * k);
            total++;
            if (obs !== {1'b1, a, 1'b0, (k == 0) ? 32'h0 : a - 32'd4, (k == 0) ? 32'h0 : 32'h13})
                $display("FAIL seq_request k=%0d got=%h exp_addr=%h", k, obs, a);
            else passed++;
            total++;
            if (stall_req !== 1'b1) $display("FAIL seq_stall_req k=%0d got=%b exp=1", k, stall_req);
            else passed++;
            tick();
            ack  = 1'b1;
            data = 32'h00000013;
            #1;
            total++;
            if (stall_req !== 1'b0) $display("FAIL seq_stall_req_ack k=%0d got=%b exp=0", k, stall_req);
            else passed++;
            tick();
            ack  = 1'b0;
            data = 32'h0;
            total++;
            if (obs !== {1'b0, a + 32'd4, 1'b1, a, 32'h13})
                $display("FAIL seq_valid k=%0d got=%h exp=%h", k, obs, {1'b0, a + 32'd4, 1'b1, a, 32'h13});
            else passed++;
            tick();
        end
    endtask

    task automatic test_stall();
        logic [31:0] w;
        w = 32'h00500093;
        do_reset();
        tick();
        ack = 1'b1; data = 32'h13; tick();
        ack = 1'b0; tick();
        ack = 1'b1; data = w; stall = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            ack  = 1'b1;
            data = 32'hFFFFFFFF;
            total++;
            if (obs !== {1'b0, 32'h8, 1'b1, 32'h4, w})
                $display("FAIL stall_hold i=%0d got=%h exp=%h", i, obs, {1'b0, 32'h8, 1'b1, 32'h4, w});
            else passed++;
            tick();
        end
        ack = 1'b0; stall = 1'b0;
        total++;
        if (obs !== {1'b0, 32'h8, 1'b1, 32'h4, w})
            $display("FAIL stall_consume got=%h exp=%h", obs, {1'b0, 32'h8, 1'b1, 32'h4, w});
        else passed++;
        tick();
        total++;
        if (obs !== {1'b1, 32'h8, 1'b0, 32'h4, w})
            $display("FAIL stall_next_req got=%h exp=%h", obs, {1'b1, 32'h8, 1'b0, 32'h4, w});
        else passed++;
    endtask

    task automatic test_branch_pending();
        do_reset();
        tick();
        repeat (2) begin
            ack = 1'b1; data = 32'h13; tick();
            ack = 1'b0; tick();
        end
        total++;
        if (obs !== {1'b1, 32'h8, 1'b0, 32'h4, 32'h13})
            $display("FAIL bp_pre got=%h exp=%h", obs, {1'b1, 32'h8, 1'b0, 32'h4, 32'h13});
        else passed++;
        b_flag = 1'b1; b_target = 32'h103; tick();
        b_flag = 1'b0; b_target = 32'h0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs !== {1'b1, 32'h8, 1'b0, 32'h4, 32'h13})
                $display("FAIL bp_addr_stable i=%0d got=%h exp=%h", i, obs, {1'b1, 32'h8, 1'b0, 32'h4, 32'h13});
            else passed++;
            if (i == 0) tick();
        end
        ack = 1'b1; data = 32'hBAD0BAD0; tick();
        ack = 1'b0;
        total++;
        if (obs !== {1'b1, 32'h100, 1'b0, 32'h4, 32'h13})
            $display("FAIL bp_dropped got=%h exp=%h", obs, {1'b1, 32'h100, 1'b0, 32'h4, 32'h13});
        else passed++;
        ack = 1'b1; data = 32'h13; tick();
        ack = 1'b0;
        total++;
        if (obs !== {1'b0, 32'h104, 1'b1, 32'h100, 32'h13})
            $display("FAIL bp_target_fetch got=%h exp=%h", obs, {1'b0, 32'h104, 1'b1, 32'h100, 32'h13});
        else passed++;
        tick();
    endtask

    task automatic test_branch_ack();
        ack = 1'b1; data = 32'hCAFEF00D; b_flag = 1'b1; b_target = 32'h200; tick();
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs !== {1'b1, 32'h200, 1'b0, 32'h100, 32'h13})
                $display("FAIL ba_dropped i=%0d got=%h exp=%h", i, obs, {1'b1, 32'h200, 1'b0, 32'h100, 32'h13});
            else passed++;
            tick();
        end
        ack = 1'b1; data = 32'h13; tick();
        ack = 1'b0;
        total++;
        if (obs !== {1'b0, 32'h204, 1'b1, 32'h200, 32'h13})
            $display("FAIL ba_target_fetch got=%h exp=%h", obs, {1'b0, 32'h204, 1'b1, 32'h200, 32'h13});
        else passed++;
        tick();
    endtask

    task automatic test_wrap();
        @(negedge clk);
        rst_w = 1'b0;
        tick();
        total++;
        if (obs_w !== {1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0})
            $display("FAIL wrap_first_req got=%h exp=%h", obs_w, {1'b1, 32'hFFFFFFFC, 1'b0, 32'h0, 32'h0});
        else passed++;
        ack_w = 1'b1; data_w = 32'h13; tick();
        ack_w = 1'b0;
        total++;
        if (obs_w !== {1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 32'h13})
            $display("FAIL wrap_valid got=%h exp=%h", obs_w, {1'b0, 32'h0, 1'b1, 32'hFFFFFFFC, 32'h13});
        else passed++;
        tick();
        total++;
        if (obs_w !== {1'b1, 32'h0, 1'b0, 32'hFFFFFFFC, 32'h13})
            $display("FAIL wrap_next_req got=%h exp=%h", obs_w, {1'b1, 32'h0, 1'b0, 32'hFFFFFFFC, 32'h13});
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        repeat (2) begin
            ack = 1'b1; data = 32'h13; tick();
            ack = 1'b0; tick();
        end
        total++;
        if (obs !== {1'b1, 32'h8, 1'b0, 32'h4, 32'h13})
            $display("FAIL rm_pre got=%h exp=%h", obs, {1'b1, 32'h8, 1'b0, 32'h4, 32'h13});
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (obs !== 98'h0) $display("FAIL rm_async_clear got=%h exp=%h", obs, 98'h0);
        else passed++;
        total++;
        if (stall_req !== 1'b0) $display("FAIL rm_stall_req got=%b exp=0", stall_req);
        else passed++;
        @(negedge clk);
        rst = 1'b0; ack = 1'b1; data = 32'hDEADBEEF;
        tick();
        ack = 1'b0; data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (obs !== {1'b1, 32'h0, 1'b0, 32'h0, 32'h0})
                $display("FAIL rm_late_ack i=%0d got=%h exp=%h", i, obs, {1'b1, 32'h0, 1'b0, 32'h0, 32'h0});
            else passed++;
            tick();
        end
    endtask

    task automatic test_random();
        logic [97:0] exp;
        logic        exp_sr;
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            exp = {m_started && !m_have, m_next, m_have, m_pc, m_inst};
            total++;
            if (obs !== exp) $display("FAIL rand_outputs cyc=%0d got=%h exp=%h", n, obs, exp);
            else passed++;
            b_flag   = ($urandom_range(7) == 0);
            b_target = $urandom;
            stall    = 1'($urandom_range(1));
            ack      = 1'($urandom_range(1));
            data     = $urandom;
            #1;
            exp_sr = m_started && !m_have && !ack;
            total++;
            if (stall_req !== exp_sr) $display("FAIL rand_stall_req cyc=%0d got=%b exp=%b", n, stall_req, exp_sr);
            else passed++;
            @(posedge clk);
            model_step();
            @(negedge clk);
        end
        clear_inputs();
    endtask

    initial begin
        rst        = 1'b1;
        clear_inputs();
        rst_w      = 1'b1;
        b_flag_w   = 1'b0;
        b_target_w = 32'h0;
        stall_w    = 1'b0;
        ack_w      = 1'b0;
        data_w     = 32'h0;
        test_reset();
        test_sequence();
        test_stall();
        test_branch_pending();
        test_branch_ack();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 b_flag_i  input  1  branch/jump taken pulse from execute stage.
REQ-005 b_target_addr_i  input  32  redirect address, valid when b_flag_i=1.
REQ-006 stall_i  input  1  decode stage cannot accept an instruction this cycle.
REQ-007 mem_req_o  output  1  instruction memory read request.
REQ-008 mem_addr_o  output  32  instruction memory read address.
REQ-009 mem_ack_i  input  1  memory read complete; mem_data_i valid this cycle.
REQ-010 mem_data_i  input  32  instruction word returned by memory.
REQ-011 pc_o  output  32  address of the instruction on inst_o.
REQ-012 inst_o  output  32  fetched instruction.
REQ-013 inst_valid_o  output  1  inst_o/pc_o hold a valid instruction.
REQ-014 stall_req_o  output  1  fetch waiting on memory; asks pipeline control to stall.

Function
REQ-015 FSM states: IDLE, REQ, HOLD; state, fetch_pc, kill flag and redirect_addr are registers.
REQ-016 IDLE: entered only from reset; next state REQ unconditionally (unless b_flag_i=1, see REQ-022), no request issued.
REQ-017 REQ: mem_req_o=1, mem_addr_o=fetch_pc; mem_addr_o stays stable until mem_ack_i=1.
REQ-018 REQ with mem_ack_i=1 and kill=0: inst_o<=mem_data_i, pc_o<=fetch_pc, inst_valid_o<=1, fetch_pc<=fetch_pc+4, next state HOLD.
REQ-019 HOLD: mem_req_o=0; inst_o, pc_o, inst_valid_o=1 held stable while stall_i=1.
REQ-020 HOLD with stall_i=0: instruction consumed this cycle; inst_valid_o<=0, next state REQ (next request one cycle later).
REQ-021 Fetch latency: ack in cycle N -> inst_valid_o=1 in cycle N+1.
REQ-022 b_flag_i=1 has priority over stall_i and mem_ack_i; target address used is {b_target_addr_i[31:2],2'b00}.
REQ-023 b_flag_i in IDLE or HOLD: fetch_pc<=target, inst_valid_o<=0, next state REQ.
REQ-024 b_flag_i in REQ with mem_ack_i=1 same cycle: returned data dropped, inst_valid_o stays 0, fetch_pc<=target, next state REQ.
REQ-025 b_flag_i in REQ with mem_ack_i=0: kill<=1, redirect_addr<=target; request continues at old address.
REQ-026 REQ with mem_ack_i=1 and kill=1: data dropped, fetch_pc<=redirect_addr, kill<=0, state stays REQ.
REQ-027 Second b_flag_i while kill=1: redirect_addr overwritten with newest target.
REQ-028 fetch_pc+4 wraps modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-029 stall_req_o = (state==REQ) && !mem_ack_i, combinational.
REQ-030 mem_ack_i outside REQ is ignored.

Reset
REQ-031 rst=1 immediately forces: state IDLE, fetch_pc=RESET_PC, kill=0, redirect_addr=0, mem_req_o=0, mem_addr_o=RESET_PC, pc_o=0, inst_o=0, inst_valid_o=0, stall_req_o=0.
REQ-032 Reset asserted mid-request aborts it; a late mem_ack_i after reset release is ignored (state IDLE).

Verification
REQ-033 Reset release, mem_ack_i returned 1 cycle after each request with data 0x00000013, stall_i=0 -> mem_addr_o sequence 0x0,0x4,0x8; inst_valid_o pulses with pc_o 0x0,0x4,0x8.
REQ-034 Ack for 0x4 with stall_i=1 for 3 cycles -> inst_valid_o, pc_o=0x4, inst_o held 3 cycles; mem_req_o=0 until stall_i drops.
REQ-035 b_flag_i=1, target 0x103, while request at 0x8 pending (ack 2 cycles later) -> mem_addr_o stays 0x8 until ack, data dropped, next request at 0x100, inst_valid_o never shows pc 0x8.
REQ-036 b_flag_i=1 same cycle as ack, target 0x200 -> no inst_valid_o for that data; next mem_addr_o=0x200.
REQ-037 RESET_PC=0xFFFFFFFC, one fetch -> pc_o=0xFFFFFFFC, next mem_addr_o=0x00000000.
REQ-038 rst pulsed while mem_req_o=1, ack arrives after release -> all outputs at reset values, ack ignored, first request at RESET_PC.
